lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Receive-side companion to the on-board LFSR pattern generator.
- Accepts the generator's parallel output word stream, self-synchronises a local LFSR predictor to it, and then checks every subsequent word.
- Reports lock status and error statistics for display and debug.
- Sits downstream of the generator (or of any link carrying its words) inside the same FPGA top level.

Parameters:
- LFSR_WIDTH, 13, width of the data word and of the predictor register.
- TAPS, 13'h1C80, feedback mask; bit i set means the polynomial includes the x^(i+1) term; default is x^13+x^12+x^11+x^8+1.
- LOCK_COUNT, 16, consecutive correct predictions required to declare lock.
- LOSS_THRESH, 8, consecutive mismatches while locked that force a return to SEARCH.
- CNT_WIDTH, 16, width of the error counter.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- data_in  input  LFSR_WIDTH  received LFSR word.
- data_valid  input  1  data_in is valid this cycle; one LFSR step per valid word.
- clr_cnt  input  1  synchronous clear of err_count.
- locked  output  1  high while in LOCKED.
- err_strb  output  1  one-cycle pulse per mismatching word while LOCKED.
- err_count  output  CNT_WIDTH  saturating count of mismatches seen while LOCKED.
- expected  output  LFSR_WIDTH  current predictor value (debug).
- state  output  2  encoded FSM state (debug).

Behaviour:
- Step function: next(x) = {x[W-2:0], ^(x & TAPS)}. This matches the generator exactly.
- Reset (rst=1 at clk edge):
  - state=SEARCH, expected=0, locked=0, err_strb=0, err_count=0.
  - Internal match and miss counters are set to 0.
  - Reset mid-operation discards lock immediately.
- All outputs are registered. err_strb and locked update on the clock edge that consumes the data_valid word, so they are visible the following cycle.
- Cycles with data_valid=0 change nothing: no step, no counter updates.
- SEARCH:
  - On a valid word equal to 0: ignore it, since 0 is the LFSR lockup value.
  - On a valid nonzero word: expected <= next(data_in), match_cnt <= 0, go to VERIFY.
- VERIFY, on each valid word:
  - If data_in==expected: match_cnt++ and expected <= next(expected). When match_cnt reaches LOCK_COUNT, go to LOCKED and assert locked.
  - If data_in!=expected: reseed with expected <= next(data_in) and match_cnt <= 0. A zero word instead returns to SEARCH.
  - No errors are counted in VERIFY.
- LOCKED, on each valid word:
  - expected <= next(expected) always (flywheel); the predictor is never reseeded from the received word.
  - On a match: miss_cnt <= 0.
  - On a mismatch: err_strb=1, err_count++ (saturating at all-ones, no wrap), miss_cnt++.
  - When miss_cnt reaches LOSS_THRESH, go to SEARCH, drop locked, and clear miss_cnt.
- clr_cnt:
  - Sets err_count to 0.
  - If asserted on the same edge as a counted error, err_count becomes 1 (clear, then count). err_strb still pulses.
  - clr_cnt does not affect lock state.
- Width rule: match_cnt and miss_cnt are $clog2(max(LOCK_COUNT, LOSS_THRESH)+1) bits.

Decomposition:
- Shared package lfsr_pkg holds:
  - the state enum (SEARCH, VERIFY, LOCKED; 2-bit encoding 0/1/2),
  - the default TAPS constant for width 13,
  - a function lfsr_next(x, taps), used by both this block and the generator.
- One natural sub-module, lfsr_predictor. It holds the expected register and implements load(seed) and step, so the checker FSM and counters stay separate.

Test Plan:
- Lock: reset, then feed 17 consecutive generator words from seed 13'h0001 (13'h0001, 13'h0002, 13'h0004, ...) with data_valid=1. Required: locked rises after the 17th word, err_count=0, err_strb never pulses.
- Single error: after lock, replace one word with its bit 0 inverted, then resume the correct sequence. Required: exactly one err_strb pulse, err_count=1, locked stays 1, and the following correct words match thanks to the flywheel.
- Loss of lock: after lock, feed 8 consecutive wrong words (e.g. all 13'h1555). Required: err_count=8, locked falls after the 8th word, state=SEARCH. Then resume a valid sequence; relock after 17 further words.
- Zero and gaps: in SEARCH, feed 13'h0000 with data_valid=1 (ignored, state stays SEARCH). Then run the lock sequence with data_valid toggling 1/0. Required: same lock result as continuous feed; idle cycles are ignored.
- Counter edges: force err_count near its maximum by holding clr_cnt low over a long error stream (CNT_WIDTH=4 build); the count must saturate at 4'hF. Then assert clr_cnt on the same edge as an error; err_count must read 1.
- Mid-run reset: assert rst for one cycle while locked. Required: next cycle locked=0, err_count=0, state=SEARCH, expected=0.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: checker FSM states, default feedback mask and the
// step function used by both the pattern generator and the checker.
package lfsr_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lfsr_state_t;

    // Widest LFSR the shared step function supports.
    localparam int LFSR_MAX_WIDTH = 32;

    // x^13 + x^12 + x^11 + x^8 + 1 (bit i set means the x^(i+1) term is present).
    localparam logic [12:0] LFSR_TAPS_13 = 13'h1C80;

    // One Fibonacci step: shift left and insert the parity of the tapped bits.
    // Callers zero-extend x and taps to LFSR_MAX_WIDTH and truncate the result
    // back to their own width; bits at or above 'width' are forced to zero.
    function automatic logic [LFSR_MAX_WIDTH-1:0] lfsr_next(
        input logic [LFSR_MAX_WIDTH-1:0] x,
        input logic [LFSR_MAX_WIDTH-1:0] taps,
        input int                        width
    );
        logic [LFSR_MAX_WIDTH-1:0] mask;
        logic                      fb;
        fb   = ^(x & taps);
        mask = '0;
        for (int i = 0; i < LFSR_MAX_WIDTH; i++) begin
            if (i < width) begin
                mask[i] = 1'b1;
            end
        end
        return ((x << 1) | {{(LFSR_MAX_WIDTH-1){1'b0}}, fb}) & mask;
    endfunction

endpackage

// File: rtl/lfsr_checker_predictor.sv
// Local LFSR predictor: holds the value the checker expects next. 'load'
// seeds it with the step after a received word, 'step' advances it by one.
module lfsr_predictor
    import lfsr_pkg::*;
#(
    parameter int                    LFSR_WIDTH = 13,
    parameter logic [LFSR_WIDTH-1:0] TAPS       = LFSR_TAPS_13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [LFSR_WIDTH-1:0] seed,
    output logic [LFSR_WIDTH-1:0] value
);

    logic [LFSR_WIDTH-1:0] step_src;
    logic [LFSR_WIDTH-1:0] step_result;

    // A load takes priority and advances from the seed rather than from the register.
    assign step_src    = load ? seed : value;
    assign step_result = LFSR_WIDTH'(lfsr_next(LFSR_MAX_WIDTH'(step_src),
                                               LFSR_MAX_WIDTH'(TAPS),
                                               LFSR_WIDTH));

    // Predictor register; only moves when the checker asks it to.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load || step) begin
            value <= step_result;
        end
    end

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: self-synchronises a local predictor to the
// incoming word stream, declares lock, then counts mismatching words.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int                    LFSR_WIDTH  = 13,
    parameter logic [LFSR_WIDTH-1:0] TAPS        = LFSR_TAPS_13,
    parameter int                    LOCK_COUNT  = 16,
    parameter int                    LOSS_THRESH = 8,
    parameter int                    CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LFSR_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    input  logic                  clr_cnt,
    output logic                  locked,
    output logic                  err_strb,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [LFSR_WIDTH-1:0] expected,
    output logic [1:0]            state
);

    localparam int RUN_MAX   = (LOCK_COUNT > LOSS_THRESH) ? LOCK_COUNT : LOSS_THRESH;
    localparam int RUN_WIDTH = $clog2(RUN_MAX + 1);

    lfsr_state_t           state_q;
    lfsr_state_t           state_d;
    logic [RUN_WIDTH-1:0]  match_cnt;
    logic [RUN_WIDTH-1:0]  match_cnt_d;
    logic [RUN_WIDTH-1:0]  miss_cnt;
    logic [RUN_WIDTH-1:0]  miss_cnt_d;
    logic [CNT_WIDTH-1:0]  err_count_d;
    logic                  err_d;
    logic                  pred_load;
    logic                  pred_step;
    logic                  is_match;
    logic                  is_zero;

    lfsr_predictor #(
        .LFSR_WIDTH (LFSR_WIDTH),
        .TAPS       (TAPS)
    ) u_predictor (
        .clk   (clk),
        .rst   (rst),
        .load  (pred_load),
        .step  (pred_step),
        .seed  (data_in),
        .value (expected)
    );

    assign is_match = (data_in == expected);
    assign is_zero  = (data_in == '0);
    assign state    = state_q;

    // Next-state, run counters and predictor control; idle cycles leave everything alone.
    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt;
        miss_cnt_d  = miss_cnt;
        err_d       = 1'b0;
        pred_load   = 1'b0;
        pred_step   = 1'b0;
        if (data_valid) begin
            case (state_q)
                SEARCH: begin
                    // Zero is the LFSR lockup value and can never seed a valid sequence.
                    if (!is_zero) begin
                        pred_load   = 1'b1;
                        match_cnt_d = '0;
                        state_d     = VERIFY;
                    end
                end
                VERIFY: begin
                    if (is_match) begin
                        pred_step   = 1'b1;
                        match_cnt_d = match_cnt + 1'b1;
                        if (match_cnt == RUN_WIDTH'(LOCK_COUNT - 1)) begin
                            state_d    = LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else if (is_zero) begin
                        match_cnt_d = '0;
                        state_d     = SEARCH;
                    end else begin
                        pred_load   = 1'b1;
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: once locked the predictor never follows the received word.
                    pred_step = 1'b1;
                    if (is_match) begin
                        miss_cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                        if (miss_cnt == RUN_WIDTH'(LOSS_THRESH - 1)) begin
                            miss_cnt_d = '0;
                            state_d    = SEARCH;
                        end else begin
                            miss_cnt_d = miss_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
    end

    // Error counter: clear first, then count, saturating at all-ones.
    always_comb begin
        err_count_d = clr_cnt ? '0 : err_count;
        if (err_d && (err_count_d != '1)) begin
            err_count_d = err_count_d + 1'b1;
        end
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SEARCH;
            match_cnt <= '0;
            miss_cnt  <= '0;
            err_count <= '0;
            err_strb  <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state_q   <= state_d;
            match_cnt <= match_cnt_d;
            miss_cnt  <= miss_cnt_d;
            err_count <= err_count_d;
            err_strb  <= err_d;
            locked    <= (state_d == LOCKED);
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed testbench for lfsr_checker (built with a 4-bit error counter so
// saturation is reachable in a short run).
module tb_lfsr_checker;

    localparam int          W       = 13;
    localparam int          CW      = 4;
    localparam logic [12:0] TB_TAPS = 13'h1C80;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  data_in;
    logic          data_valid;
    logic          clr_cnt;
    logic          locked;
    logic          err_strb;
    logic [CW-1:0] err_count;
    logic [W-1:0]  expected;
    logic [1:0]    state;

    int            n_compared   = 0;
    int            n_mismatched = 0;
    logic [W-1:0]  gen_word;
    logic          strobe_seen;

    lfsr_checker #(
        .LFSR_WIDTH  (W),
        .TAPS        (TB_TAPS),
        .LOCK_COUNT  (16),
        .LOSS_THRESH (8),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .clr_cnt    (clr_cnt),
        .locked     (locked),
        .err_strb   (err_strb),
        .err_count  (err_count),
        .expected   (expected),
        .state      (state)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    // Reference step written bit by bit, independent of the package function.
    function automatic logic [W-1:0] model_next(input logic [W-1:0] x);
        logic fb;
        fb = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (TB_TAPS[i]) begin
                fb = fb ^ x[i];
            end
        end
        return {x[W-2:0], fb};
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] required);
        n_compared++;
        if (observed !== required) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, required 0x%0h", tag, observed, required);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the consuming edge.
    task automatic applyStimulus(input logic valid, input logic [W-1:0] word, input logic clear);
        data_valid = valid;
        data_in    = word;
        clr_cnt    = clear;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        clr_cnt    = 1'b0;
        if (err_strb) begin
            strobe_seen = 1'b1;
        end
    endtask

    // Send the next correct generator word and advance the reference generator.
    task automatic sendGood();
        applyStimulus(1'b1, gen_word, 1'b0);
        gen_word = model_next(gen_word);
    endtask

    // Send a deliberately corrupted word in place of the next generator word.
    task automatic sendBad(input logic [W-1:0] flip, input logic clear);
        applyStimulus(1'b1, gen_word ^ flip, clear);
        gen_word = model_next(gen_word);
    endtask

    initial begin
        rst         = 1'b1;
        data_in     = '0;
        data_valid  = 1'b0;
        clr_cnt     = 1'b0;
        strobe_seen = 1'b0;
        gen_word    = 13'h0001;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_locked", 16'(locked), 16'd0);
        checkOutput("reset_err_strb", 16'(err_strb), 16'd0);
        checkOutput("reset_err_count", 16'(err_count), 16'd0);
        checkOutput("reset_state", 16'(state), 16'd0);
        checkOutput("reset_expected", 16'(expected), 16'd0);
        rst = 1'b0;

        $display("[TB] zero word and reseed behaviour");
        applyStimulus(1'b1, 13'h0000, 1'b0);
        checkOutput("zero_search_state", 16'(state), 16'd0);
        checkOutput("zero_search_expected", 16'(expected), 16'd0);
        applyStimulus(1'b1, 13'h0ABC, 1'b0);
        checkOutput("seed_state", 16'(state), 16'd1);
        checkOutput("seed_expected", 16'(expected), 16'(model_next(13'h0ABC)));
        applyStimulus(1'b1, 13'h0123, 1'b0);
        checkOutput("reseed_state", 16'(state), 16'd1);
        checkOutput("reseed_expected", 16'(expected), 16'(model_next(13'h0123)));
        applyStimulus(1'b1, 13'h0000, 1'b0);
        checkOutput("verify_zero_state", 16'(state), 16'd0);

        $display("[TB] lock from seed 0x0001");
        gen_word    = 13'h0001;
        strobe_seen = 1'b0;
        repeat (16) sendGood();
        checkOutput("prelock_locked", 16'(locked), 16'd0);
        checkOutput("prelock_state", 16'(state), 16'd1);
        sendGood();
        checkOutput("lock_locked", 16'(locked), 16'd1);
        checkOutput("lock_state", 16'(state), 16'd2);
        checkOutput("lock_err_count", 16'(err_count), 16'd0);
        checkOutput("lock_no_strobe", 16'(strobe_seen), 16'd0);
        checkOutput("lock_expected", 16'(expected), 16'(gen_word));

        $display("[TB] single corrupted word");
        sendBad(13'h0001, 1'b0);
        checkOutput("single_err_strb", 16'(err_strb), 16'd1);
        checkOutput("single_err_count", 16'(err_count), 16'd1);
        checkOutput("single_locked", 16'(locked), 16'd1);
        strobe_seen = 1'b0;
        repeat (5) sendGood();
        checkOutput("flywheel_no_strobe", 16'(strobe_seen), 16'd0);
        checkOutput("flywheel_err_count", 16'(err_count), 16'd1);
        checkOutput("flywheel_locked", 16'(locked), 16'd1);
        checkOutput("flywheel_expected", 16'(expected), 16'(gen_word));

        $display("[TB] loss of lock");
        applyStimulus(1'b1, gen_word, 1'b1);
        gen_word = model_next(gen_word);
        checkOutput("clear_err_count", 16'(err_count), 16'd0);
        checkOutput("clear_locked", 16'(locked), 16'd1);
        repeat (7) sendBad(13'h1555, 1'b0);
        checkOutput("loss7_locked", 16'(locked), 16'd1);
        checkOutput("loss7_err_count", 16'(err_count), 16'd7);
        sendBad(13'h1555, 1'b0);
        checkOutput("loss8_err_strb", 16'(err_strb), 16'd1);
        checkOutput("loss8_err_count", 16'(err_count), 16'd8);
        checkOutput("loss8_locked", 16'(locked), 16'd0);
        checkOutput("loss8_state", 16'(state), 16'd0);

        $display("[TB] relock with idle gaps");
        strobe_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sendGood();
            applyStimulus(1'b0, 13'h1FFF, 1'b0);
            checkOutput("gap_expected", 16'(expected), 16'(gen_word));
        end
        checkOutput("gap_prelock_locked", 16'(locked), 16'd0);
        checkOutput("gap_prelock_state", 16'(state), 16'd1);
        sendGood();
        checkOutput("gap_lock_locked", 16'(locked), 16'd1);
        checkOutput("gap_lock_state", 16'(state), 16'd2);
        checkOutput("gap_err_count", 16'(err_count), 16'd8);
        checkOutput("gap_no_strobe", 16'(strobe_seen), 16'd0);

        $display("[TB] counter saturation and clear-with-error");
        for (int i = 0; i < 10; i++) begin
            sendBad(13'h0004, 1'b0);
            sendGood();
        end
        checkOutput("sat_err_count", 16'(err_count), 16'hF);
        checkOutput("sat_locked", 16'(locked), 16'd1);
        sendBad(13'h0001, 1'b1);
        checkOutput("clr_err_count", 16'(err_count), 16'd1);
        checkOutput("clr_err_strb", 16'(err_strb), 16'd1);
        checkOutput("clr_locked", 16'(locked), 16'd1);

        $display("[TB] reset while locked");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midrst_locked", 16'(locked), 16'd0);
        checkOutput("midrst_err_count", 16'(err_count), 16'd0);
        checkOutput("midrst_err_strb", 16'(err_strb), 16'd0);
        checkOutput("midrst_state", 16'(state), 16'd0);
        checkOutput("midrst_expected", 16'(expected), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
